// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes,
// fault cause encodings and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Illegal funct3 outranks misalignment.
  function automatic logic [1:0] req_cause(
    input logic       write,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic illegal;
    logic misal;
    illegal = write ? (f3 > F3_W)
                    : (f3 == 3'b011 || f3[2:1] == 2'b11);
    misal = (f3[1:0] == 2'b01 && off[0]) ||
            (f3[1:0] == 2'b10 && off != 2'b00);
    if (illegal)    return CAUSE_ILLEGAL;
    else if (misal) return CAUSE_MISALIGN;
    else            return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension.
// Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] mem_rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [SIZE-1:0] load_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = mem_rdata[{addr, 3'b000} +: 8];
    w_half     = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_value = '0;
    case (funct3)
      F3_B:    load_value = {{(SIZE-8){w_byte[7]}}, w_byte};
      F3_H:    load_value = {{(SIZE-16){w_half[15]}}, w_half};
      F3_W:    load_value = mem_rdata;
      F3_BU:   load_value = {{(SIZE-8){1'b0}}, w_byte};
      F3_HU:   load_value = {{(SIZE-16){1'b0}}, w_half};
      default: load_value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with valid/ready data-memory port.
// Define LSU_TIMEOUT_EN to enable the WAIT-state response watchdog.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [SIZE-1:0] address,
  input  logic [SIZE-1:0] store_data,
  output logic            busy,
  output logic            resp_valid,
  output logic [SIZE-1:0] load_data,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [SIZE-1:0] mem_rdata
);

  lsu_state_e      r_state;
  lsu_state_e      w_next;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [SIZE-1:0] r_mem_addr;
  logic [SIZE-1:0] r_mem_wdata;
  logic [3:0]      r_mem_wstrb;
  logic [SIZE-1:0] r_load_data;
  logic            r_fault;
  logic [1:0]      r_cause;
  logic [1:0]      w_req_cause;
  logic [SIZE-1:0] w_wdata;
  logic [3:0]      w_wstrb;
  logic [SIZE-1:0] w_aligned;
  logic            w_accept;
  logic            w_expire;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]      r_cnt;
`endif

  lsu_load_align #(.SIZE(SIZE)) u_align (
    .mem_rdata  (mem_rdata),
    .addr       (r_off),
    .funct3     (r_funct3),
    .load_value (w_aligned)
  );

  assign w_req_cause = req_cause(req_write, req_funct3, address[1:0]);
  assign w_accept    = (r_state == S_IDLE) && req_valid;

`ifdef LSU_TIMEOUT_EN
  assign w_expire = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid)
                w_next = (w_req_cause == CAUSE_NONE) ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready)
                w_next = r_write ? S_DONE : S_WAIT;
      S_WAIT: if (mem_rsp_valid || w_expire)
                w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Store lanes are replicated so the bus only needs the strobe.
  always_comb begin
    w_wdata = store_data;
    w_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        w_wdata = {4{store_data[7:0]}};
        w_wstrb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data[15:0]}};
        w_wstrb = address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
      r_cause     <= CAUSE_NONE;
    end else if (w_accept) begin
      r_write     <= req_write;
      r_funct3    <= req_funct3;
      r_off       <= address[1:0];
      r_mem_addr  <= {address[SIZE-1:2], 2'b00};
      r_mem_wdata <= w_wdata;
      r_mem_wstrb <= w_wstrb;
      r_load_data <= '0;
      r_fault     <= (w_req_cause != CAUSE_NONE);
      r_cause     <= w_req_cause;
    end else if (r_state == S_WAIT) begin
      if (mem_rsp_valid) begin
        r_load_data <= w_aligned;
      end else if (w_expire) begin
`ifdef LSU_TIMEOUT_EN
        r_fault <= 1'b1;
        r_cause <= CAUSE_TIMEOUT;
`endif
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 8'd1;
  end
`endif

  assign busy = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
  assign resp_valid    = (r_state == S_DONE);
  assign load_data     = r_load_data;
  assign fault         = r_fault;
  assign fault_cause   = r_cause;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_we        = r_write;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a word-level reference
// memory model and a per-cycle compare process.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] address, store_data;
  logic        busy, resp_valid, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.SIZE(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .address(address),
    .store_data(store_data), .busy(busy),
    .resp_valid(resp_valid), .load_data(load_data),
    .fault(fault), .fault_cause(fault_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  bit        chk_en = 0;
  bit        e_busy, e_resp, e_mreq, e_rz, e_ldchk, e_we, e_fault;
  bit [31:0] e_addr, e_wdata, e_ld;
  bit [3:0]  e_strb;
  bit [1:0]  e_cause;

  bit [31:0] ref_mem [16];
  bit [31:0] bus_mem [16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected values are set by the driver #1 after posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("resp_valid", resp_valid, e_resp);
      chk("mem_req_valid", mem_req_valid, e_mreq);
      if (e_mreq) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_we);
        if (e_we) begin
          chk("mem_wdata", mem_wdata, e_wdata);
          chk("mem_wstrb", mem_wstrb, e_strb);
        end
      end
      if (e_resp) begin
        chk("fault", fault, e_fault);
        chk("fault_cause", fault_cause, e_cause);
        if (e_ldchk) chk("load_data", load_data, e_ld);
      end
      if (e_rz) begin
        chk("rst_load_data", load_data, 0);
        chk("rst_fault", {fault, fault_cause}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb_we", {mem_we, mem_wstrb}, 0);
      end
    end
  end

  function automatic int size_of(bit [2:0] f3);
    if (f3[1:0] == 2'b00)      return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else                       return 4;
  endfunction

  function automatic bit [1:0] exp_cause(bit w, bit [2:0] f3, bit [31:0] a);
    bit ill;
    ill = w ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    if (ill) return 2;
    if ((a % size_of(f3)) != 0) return 1;
    return 0;
  endfunction

  function automatic bit [31:0] load_val(bit [31:0] word, bit [1:0] off,
                                         bit [2:0] f3);
    int sz;
    bit [31:0] v, m;
    sz = size_of(f3);
    if (sz == 4) return word;
    m = (32'd1 << (8 * sz)) - 1;
    v = (word >> (8 * off)) & m;
    if (!f3[2] && v[8*sz-1]) v = v - (m + 1);
    return v;
  endfunction

  function automatic bit [31:0] exp_wdata(bit [2:0] f3, bit [31:0] d);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return d[7:0] * 32'h01010101;
    if (sz == 2) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  function automatic bit [3:0] exp_strb(bit [2:0] f3, bit [31:0] a);
    return 4'(((1 << size_of(f3)) - 1) << (a % 4));
  endfunction

  task automatic pin(string nm, logic [31:0] act, logic [31:0] exp);
    chk(nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 0;
    e_busy = 0; e_resp = 0; e_mreq = 0; e_rz = 0;
  endtask

  task automatic drive_req(bit w, bit [2:0] f3, bit [31:0] a,
                           bit [31:0] d);
    req_valid = 1; req_write = w; req_funct3 = f3;
    address = a; store_data = d;
    e_busy = 1; e_resp = 0; e_mreq = 0; e_rz = 0;
  endtask

  task automatic run_op(bit w, bit [2:0] f3, bit [31:0] a, bit [31:0] d,
                        int stall, int dly);
    int idx, sz;
    bit [1:0] cause;
    bit [31:0] cw;
    bit [3:0] cs;
    sz = size_of(f3);
    idx = int'((a >> 2) % 16);
    cause = exp_cause(w, f3, a);
    drive_req(w, f3, a, d);
    mem_req_ready = 1'($urandom % 2);
    mem_rsp_valid = 1'($urandom % 2);
    mem_rdata = $urandom;
    cyc();
    if (cause != 0) begin
      mem_rsp_valid = 1'($urandom % 2);
      e_busy = 0; e_resp = 1; e_fault = 1; e_cause = cause;
      e_ld = 0; e_ldchk = 1;
      cyc();
    end else begin
      e_addr = a - (a % 4); e_we = w;
      e_wdata = exp_wdata(f3, d); e_strb = exp_strb(f3, a);
      cw = 0; cs = 0;
      for (int i = 0; i <= stall; i++) begin
        mem_req_ready = (i == stall);
        mem_rsp_valid = (i == stall) ? 1'b0 : 1'($urandom % 2);
        mem_rdata = $urandom;
        e_busy = 1; e_mreq = 1; e_resp = 0;
        if (i == stall) begin cw = mem_wdata; cs = mem_wstrb; end
        cyc();
      end
      e_mreq = 0;
      mem_req_ready = 1'($urandom % 2);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (cs[k]) bus_mem[idx][8*k +: 8] = cw[8*k +: 8];
        for (int k = 0; k < sz; k++)
          ref_mem[idx][8*(int'(a % 4) + k) +: 8] = d[8*k +: 8];
        mem_rsp_valid = 1'($urandom % 2);
        e_busy = 0; e_resp = 1; e_fault = 0; e_cause = 0; e_ldchk = 0;
        cyc();
      end else begin
        e_ld = load_val(ref_mem[idx], a[1:0], f3);
        for (int j = 0; j <= dly; j++) begin
          mem_rsp_valid = (j == dly);
          mem_rdata = (j == dly) ? bus_mem[idx] : $urandom;
          mem_req_ready = 1'($urandom % 2);
          e_busy = 1; e_resp = 0;
          cyc();
        end
        mem_rsp_valid = 1'($urandom % 2);
        mem_rdata = $urandom;
        e_busy = 0; e_resp = 1; e_fault = 0; e_cause = 0; e_ldchk = 1;
        cyc();
      end
    end
    set_idle();
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle();
    e_rz = 1;
    cyc();
    cyc();
    rst = 0;
    cyc();
    e_rz = 0;
  endtask

  task automatic start_load_handshake(bit [31:0] a);
    drive_req(0, 3'b010, a, 0);
    cyc();
    e_addr = a; e_we = 0;
    mem_req_ready = 1; e_mreq = 1;
    cyc();
    mem_req_ready = 0; e_mreq = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit w;
    bit [2:0] f3;
    bit [31:0] a;
    int off, sz;
    rst = 1;
    req_valid = 0; req_write = 0; req_funct3 = 0;
    address = 0; store_data = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    pin("pin_lw", load_val(32'hDEADBEEF, 2'd0, 3'b010), 32'hDEADBEEF);
    pin("pin_lb", load_val(32'h80FF0000, 2'd3, 3'b000), 32'hFFFFFF80);
    pin("pin_lbu", load_val(32'h80FF0000, 2'd3, 3'b100), 32'h00000080);
    pin("pin_sh_wdata", exp_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    pin("pin_sh_strb", exp_strb(3'b001, 32'h202), 32'hC);
    pin("pin_misalign", exp_cause(0, 3'b010, 32'h101), 1);
    pin("pin_illegal", exp_cause(1, 3'b100, 32'h0), 2);
    set_idle();
    e_rz = 1;
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    cyc();
    e_rz = 0;

    ref_mem[0] = 32'hDEADBEEF; bus_mem[0] = ref_mem[0];
    run_op(0, 3'b010, 32'h100, 0, 0, 0);
    ref_mem[0] = 32'h80FF0000; bus_mem[0] = ref_mem[0];
    run_op(0, 3'b000, 32'h103, 0, 0, 0);
    run_op(0, 3'b100, 32'h103, 0, 0, 1);
    run_op(1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0);
    run_op(0, 3'b010, 32'h101, 0, 0, 0);
    run_op(1, 3'b100, 32'h104, 32'h55, 0, 0);

    start_load_handshake(32'h108);
`ifdef LSU_TIMEOUT_EN
    for (int j = 0; j < 4; j++) begin
      e_busy = 1; e_resp = 0;
      cyc();
    end
    e_busy = 0; e_resp = 1; e_fault = 1; e_cause = 2'b11;
    e_ld = 0; e_ldchk = 1;
    cyc();
    set_idle();
    cyc();
`else
    for (int j = 0; j < 20; j++) begin
      e_busy = 1; e_resp = 0;
      cyc();
    end
`endif
    do_reset();

    drive_req(0, 3'b010, 32'h104, 0);
    cyc();
    e_addr = 32'h104; e_we = 0; e_mreq = 1;
    cyc();
    rst = 1;
    set_idle();
    e_rz = 1;
    cyc();
    rst = 0;
    cyc();
    e_rz = 0;
    run_op(0, 3'b010, 32'h104, 0, 1, 1);

    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom % 2);
      if ($urandom % 8 == 0) f3 = 3'($urandom % 8);
      else if (w) f3 = 3'($urandom % 3);
      else begin
        case ($urandom % 5)
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      sz = size_of(f3);
      if ($urandom % 5 == 0) off = int'($urandom % 4);
      else off = int'($urandom % 4) & ~(sz - 1);
      a = 32'h100 + ($urandom % 16) * 4 + 32'(off);
      run_op(w, f3, a, $urandom, int'($urandom % 3), int'($urandom % 3));
      if ($urandom % 4 == 0) cyc();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU: consumes the ALU `result` as the effective address plus rs2 as store data. It drives a valid/ready data-memory port, aligns and extends load data, and stalls the core via `busy` until the access completes. It is the memory stage that turns the single-cycle core's loads and stores into bus transactions.

## Interface
- `SIZE`, 32, address/data width; must be 32.
- `TIMEOUT_CYCLES`, 255, WAIT-state watchdog limit; used only with `LSU_TIMEOUT_EN`.

Ports (`name  direction  width  meaning`):
- `clk  in  1  clock`, rising edge.
- `rst  in  1  reset`, asynchronous, active-high.
- `req_valid  in  1  core presents a load/store this cycle`
- `req_write  in  1  1 = store, 0 = load`
- `req_funct3  in  3  RISC-V funct3`: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `address  in  SIZE  effective address (ALU result)`
- `store_data  in  SIZE  rs2 value`
- `busy  out  1  stall core PC/regfile write`
- `resp_valid  out  1  one-cycle pulse: access finished`
- `load_data  out  SIZE  extended load result, valid with resp_valid`
- `fault  out  1  access faulted, valid with resp_valid`
- `fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout`
- `mem_req_valid  out  1`, `mem_req_ready  in  1`: request handshake.
- `mem_we  out  1`, `mem_addr  out  SIZE` (word-aligned, bits[1:0] = 0), `mem_wdata  out  SIZE`, `mem_wstrb  out  4`.
- `mem_rsp_valid  in  1`, `mem_rdata  in  SIZE`: load response.

## Operation
States:
- **IDLE**
  - `req_valid` with a legal, aligned request: capture the request and go to REQ.
  - Misaligned or illegal request: record the cause and go to DONE with no bus activity.
  - Misaligned means LH/LHU/SH with `address[0]` set, or LW/SW with `address[1:0]` ≠ 0.
  - Illegal means load funct3 011/110/111, or store funct3 ≥ 011.
  - Illegal funct3 takes priority over misaligned.
- **REQ**
  - Hold `mem_req_valid` = 1 with stable address, data, strobe and `mem_we` until `mem_req_ready`.
  - On handshake, a store goes to DONE and a load goes to WAIT.
- **WAIT**
  - On `mem_rsp_valid`, latch the aligned/extended data and go to DONE.
- **DONE**
  - `resp_valid` = 1 for exactly one cycle, then go to IDLE.
  - `req_valid` is ignored here: it is still the same instruction.

Output rules:
- `busy` = (state ∉ {IDLE, DONE}) or (state = IDLE and `req_valid`). It is low in DONE so the core retires that cycle.
- Store lanes:
  - SB replicates `store_data[7:0]` to all 4 bytes; strobe is 0001 shifted left by `address[1:0]`.
  - SH replicates `[15:0]` to both halves; strobe is 0011 or 1100 by `address[1]`.
  - SW uses strobe 1111.
- Loads select the byte or half by `address[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- On fault, `load_data` = 0. A faulted store never asserts `mem_req_valid`.
- `mem_rsp_valid` outside WAIT is ignored. Memory never responds in the handshake cycle.

Reset:
- Asynchronous reset in any state returns to IDLE.
- All outputs and registers go to 0, including `mem_req_valid` mid-handshake and `busy`. `busy` is then 0 unless `req_valid` is asserted.

## Timing
Latency is counted from the IDLE accept cycle T0, with zero-wait memory.
- **Load:** REQ handshake at T1, response at T2, `resp_valid` at T3.
- **Store:** handshake at T1, `resp_valid` at T2.
- **Fault:** `resp_valid` at T1.
- **Backpressure:** each cycle of `mem_req_ready` low adds one cycle. Each cycle of response delay adds one cycle.
- **Register boundaries:** `load_data`, `fault` and `fault_cause` are registered and stable only while `resp_valid` = 1. Mem-side outputs are registered.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `mem_rsp_valid`, go to DONE with `fault` = 1, cause 11, `load_data` = 0.
  - A response arriving in the same cycle as expiry wins (no fault).
- **Undefined:** no counter; WAIT lasts indefinitely; cause 11 is never produced.

## Structure
- **Package `lsu_pkg`:** state enum (IDLE, REQ, WAIT, DONE), funct3 constants, `fault_cause` encodings.
- **Sub-module `lsu_load_align`:** combinational; inputs `mem_rdata`, `addr[1:0]`, funct3; output the extended load value.

## Test plan
- **LW:** `address` 0x100, ready = 1, response next cycle with rdata 0xDEADBEEF → `mem_addr` 0x100, `resp_valid` at T3, `load_data` 0xDEADBEEF, `busy` high T0–T2.
- **LB / LBU:** `address` 0x103, rdata 0x80FF_0000 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SH:** `address` 0x202, data 0x1234ABCD, ready low for 3 cycles → `mem_addr` 0x200, wstrb 1100, wdata 0xABCDABCD held stable, `resp_valid` 4 cycles after T1.
- **Faults:**
  - LW at 0x101 → fault, cause 01, `resp_valid` at T1, no `mem_req_valid`.
  - Store funct3 100 → cause 10.
- **Timeout** (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4): load with no response → cause 11 after 4 WAIT cycles. Without the macro → `busy` stays high.
- **Reset:** assert `rst` in REQ → `mem_req_valid` 0 immediately; IDLE after release; the next LW completes normally.
